probe_capture: RTL

PROBE_CAPTURE -- requirements
Module: probe_capture

---
 rtl/probe_capture.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/probe_capture.sv
// Logic-analyser style probe capture: edge/forced trigger fills a DEPTH-entry buffer, 1-cycle registered reads.
// Optional macro CAP_LOAD_EN adds a per-channel bank of load flip-flops with a registered XOR parity output.
module probe_capture #(
  parameter int CH_NUM = 8,
  parameter int FF_NUM = 8,
  parameter int DEPTH  = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] probe,
  input  logic [CH_NUM-1:0] trig_mask,
  input  logic              arm,
  input  logic              force_trig,
  input  logic              abort,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [CH_NUM-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic              done,
  output logic [AW:0]       wr_count,
  output logic              load_parity
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  if (CH_NUM < 1 || CH_NUM > 64) begin : g_bad_ch
    $error("CH_NUM out of range");
  end
  if (FF_NUM < 1) begin : g_bad_ff
    $error("FF_NUM must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  state_e            state_q, state_d;
  logic [CH_NUM-1:0] s0_q, s1_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              done_q;
  logic              rd_valid_q;
  logic [CH_NUM-1:0] rd_data_q;
  logic [CH_NUM-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic              trig;

  assign trig = (|((s0_q ^ s1_q) & trig_mask)) | force_trig;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        if (trig) begin
          wr_en   = 1'b1;
          cnt_d   = (AW+1)'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q[AW-1:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == (AW+1)'(DEPTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (arm) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort beats every other event in the same cycle, including the pending write
    if (abort) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      s0_q       <= '0;
      s1_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= (state_d == DONE);
      s0_q       <= probe;
      s1_q       <= s0_q;
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
    end
  end

  // Buffer is never cleared; reset only blocks the write in flight.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_addr] <= s0_q;
  end

`ifdef CAP_LOAD_EN
  logic [CH_NUM-1:0][FF_NUM-1:0] load_q;
  logic                          parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) load_q[c] <= {FF_NUM{s0_q[c]}};
      parity_q <= ^load_q;
    end
  end

  assign load_parity = parity_q;
`else
  assign load_parity = 1'b0;
`endif

  assign state    = state_q;
  assign done     = done_q;
  assign wr_count = cnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
